euler_step_scheduler: RTL and testbench

EULER_STEP_SCHEDULER -- requirements
Module: euler_step_scheduler

---
 rtl/euler_pkg.sv | 8 +
 rtl/euler_watchdog.sv | 19 +
 rtl/euler_step_scheduler.sv | 123 ++++++++++++
 tb/tb_euler_step_scheduler.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/euler_pkg.sv
// euler_pkg: scheduler state encoding and err_code values shared by the Euler step scheduler files.
package euler_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE, S_ERR} state_t;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CFG     = 2'b01;
    localparam logic [1:0] ERR_CORE    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;
endpackage

// File: rtl/euler_watchdog.sv
// euler_watchdog: counts enabled cycles since the last clear and flags the TIMEOUT-th one.
module euler_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end
    assign expired = enable && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/euler_step_scheduler.sv
// euler_step_scheduler: walks time from t0 to t_end in steps of at most h_step,
// launching one external Euler core step per iteration and guarding each with a watchdog.
module euler_step_scheduler
    import euler_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int CNT_SIZE  = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DATA_SIZE-1:0] t0,
    input  logic [DATA_SIZE-1:0] t_end,
    input  logic [DATA_SIZE-1:0] h_step,
    output logic                 core_start,
    output logic [DATA_SIZE-1:0] core_h,
    input  logic                 core_finish,
    input  logic                 core_error,
    output logic [DATA_SIZE-1:0] t_now,
    output logic [CNT_SIZE-1:0]  step_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code
);
    state_t state, state_n;
    logic [1:0] err_n;
    logic [DATA_SIZE-1:0] t_end_r, h_r, t_sum, rem, h_eff;
    logic first_wait, expired;

    euler_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk(clk),
        .rst(rst),
        .clear(state == S_ISSUE),
        .enable(state == S_WAIT),
        .expired(expired)
    );

    // in ADVANCE the next step size is taken from the time being committed this cycle
    assign t_sum = t_now + core_h;
    assign rem   = t_end_r - (state == S_ADVANCE ? t_sum : t_now);
    assign h_eff = h_r < rem ? h_r : rem;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n    = state;
        err_n      = err_code;
        core_start = state == S_ISSUE;
        busy       = state inside {S_LOAD, S_ISSUE, S_WAIT, S_ADVANCE};
        done       = state inside {S_DONE, S_ERR};
        error      = state == S_ERR;
        case (state)
            S_IDLE: if (start) state_n = S_LOAD;
            S_LOAD: begin
                if (h_r == '0 || t_end_r < t_now) begin
                    state_n = S_ERR;
                    err_n   = ERR_CFG;
                end else state_n = t_end_r == t_now ? S_DONE : S_ISSUE;
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (core_error) begin
                    state_n = S_ERR;
                    err_n   = ERR_CORE;
                end else if (core_finish && !first_wait) state_n = S_ADVANCE;
                else if (expired) begin
                    state_n = S_ERR;
                    err_n   = ERR_TIMEOUT;
                end
            end
            S_ADVANCE: begin
                if (t_sum == t_end_r) state_n = S_DONE;
                else if (&step_count) begin
                    state_n = S_ERR;
                    err_n   = ERR_TIMEOUT;
                end else state_n = S_ISSUE;
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_n = S_LOAD;
                    err_n   = ERR_NONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (abort) begin
            state_n = S_IDLE;
            err_n   = ERR_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            t_end_r    <= '0;
            h_r        <= '0;
            t_now      <= '0;
            step_count <= '0;
            core_h     <= '0;
            first_wait <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            if (state_n == S_LOAD) begin
                t_end_r    <= t_end;
                h_r        <= h_step;
                t_now      <= t0;
                step_count <= '0;
            end else if (state == S_ADVANCE && !abort) begin
                t_now      <= t_sum;
                step_count <= &step_count ? step_count : step_count + 1'b1;
            end
            if (state_n == S_ISSUE) core_h <= h_eff;
            // a finish level still high from the previous step must not be taken on the first WAIT cycle
            first_wait <= state == S_ISSUE;
            err_code   <= err_n;
        end
    end
endmodule

// File: tb/tb_euler_step_scheduler.sv
// tb_euler_step_scheduler: directed runs against a small behavioural core with hand-computed expectations.
module tb_euler_step_scheduler;
    localparam int TO = 20;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, core_finish = 1'b0, core_error = 1'b0;
    logic [15:0] t0 = '0, t_end = '0, h_step = '0;
    logic core_start, busy, done, error;
    logic [15:0] core_h, t_now, step_count;
    logic [1:0] err_code;
    int total = 0, bad = 0;
    logic [15:0] hs [8];
    int pulses, gap, lat_fin, lat_start;

    euler_step_scheduler #(.DATA_SIZE(16), .CNT_SIZE(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .t0(t0), .t_end(t_end), .h_step(h_step),
        .core_start(core_start), .core_h(core_h),
        .core_finish(core_finish), .core_error(core_error),
        .t_now(t_now), .step_count(step_count),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        @(negedge clk);
        t0 = a;
        t_end = b;
        h_step = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // core model: finish rises delay cycles after core_start and stays high until two cycles into the next step
    task automatic run_core(input int delay, input int err_step);
        int cd = -1, drop = -1, fin_cyc = -100, last = 0;
        pulses = 0;
        gap = 0;
        lat_fin = -1;
        lat_start = -1;
        core_finish = 1'b0;
        core_error = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (done) begin
                lat_fin = cyc - fin_cyc;
                lat_start = cyc - last;
                break;
            end
            if (drop > 0) begin
                drop--;
                if (drop == 0) core_finish = 1'b0;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    core_finish = 1'b1;
                    core_error = pulses == err_step;
                    fin_cyc = cyc;
                end
            end
            if (core_start) begin
                if (pulses == 1) gap = cyc - last;
                last = cyc;
                if (pulses < 8) hs[pulses] = core_h;
                pulses++;
                cd = delay;
                drop = 2;
            end
        end
        core_finish = 1'b0;
        core_error = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_flags", {core_start, busy, done, error, err_code}, 0);
        check("rst_data", {core_h, t_now}, 0);
        check("rst_cnt", step_count, 0);
        rst = 1'b1;

        launch(16'h0000, 16'h0100, 16'h0040);
        check("r1_busy", busy, 1);
        run_core(5, -1);
        check("r1_pulses", pulses, 4);
        check("r1_h01", {hs[0], hs[1]}, 32'h0040_0040);
        check("r1_h23", {hs[2], hs[3]}, 32'h0040_0040);
        check("r1_t_now", t_now, 16'h0100);
        check("r1_steps", step_count, 4);
        check("r1_flags", {busy, done, error, err_code}, 5'b01000);
        check("r1_gap", gap, 7);
        check("r1_fin_to_done", lat_fin, 2);
        @(negedge clk);
        check("r1_hold", {done, t_now}, {1'b1, 16'h0100});

        launch(16'h0000, 16'h0100, 16'h0060);
        run_core(5, -1);
        check("r2_pulses", pulses, 3);
        check("r2_h01", {hs[0], hs[1]}, 32'h0060_0060);
        check("r2_h2", hs[2], 16'h0040);
        check("r2_steps", step_count, 3);
        check("r2_t_now", t_now, 16'h0100);

        launch(16'h0000, 16'h0100, 16'h0000);
        check("r3_load_no_start", core_start, 0);
        @(negedge clk);
        check("r3_cfg_err", {busy, done, error, err_code}, 5'b01101);

        launch(16'h0050, 16'h0050, 16'h0010);
        @(negedge clk);
        check("r3b_empty", {done, error, err_code}, 4'b1000);
        check("r3b_steps", step_count, 0);
        check("r3b_t_now", t_now, 16'h0050);

        launch(16'h0000, 16'h0100, 16'h0040);
        run_core(5, 2);
        check("r4_pulses", pulses, 2);
        check("r4_core_err", {done, error, err_code}, 4'b1110);
        check("r4_steps", step_count, 1);
        check("r4_t_now", t_now, 16'h0040);

        launch(16'h0000, 16'h0100, 16'h0040);
        run_core(10000, -1);
        check("r5_pulses", pulses, 1);
        check("r5_timeout", {done, error, err_code}, 4'b1111);
        check("r5_steps", step_count, 0);
        check("r5_wait_len", lat_start, TO + 1);

        launch(16'h0000, 16'h0100, 16'h0040);
        check("r6_load", {core_start, busy, err_code}, 4'b0100);
        @(negedge clk);
        check("r6_issue", {core_start, core_h}, {1'b1, 16'h0040});
        @(negedge clk);
        check("r6_one_shot", {core_start, busy}, 2'b01);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("r6_abort", {core_start, busy, done, error}, 0);
        @(negedge clk);
        check("r6_idle", {busy, done}, 0);

        launch(16'h0010, 16'h0100, 16'h0040);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("r7_rst_flags", {core_start, busy, done, error, err_code}, 0);
        check("r7_rst_data", {core_h, t_now}, 0);
        check("r7_rst_cnt", step_count, 0);
        rst = 1'b1;

        launch(16'h0000, 16'h0100, 16'h0040);
        run_core(5, -1);
        check("r8_done", {done, error, err_code}, 4'b1000);
        check("r8_steps", step_count, 4);
        check("r8_t_now", t_now, 16'h0100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
